// File: rtl/seq_karatsuba_pkg.sv
// Shared definitions for the sequential Karatsuba multiplier.
//   state_t     : FSM state encoding (IDLE, MUL_HH, MUL_LL, MUL_MID, COMBINE, DONE)
//   half_width  : derives the half operand width H from N
//   width_ok    : elaboration-time legality test for N (even, >= 4)
package seq_karatsuba_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_HH  = 3'd1,
        MUL_LL  = 3'd2,
        MUL_MID = 3'd3,
        COMBINE = 3'd4,
        DONE    = 3'd5
    } state_t;

    function automatic int half_width(input int n);
        return n / 2;
    endfunction

    function automatic bit width_ok(input int n);
        return (n >= 4) && ((n % 2) == 0);
    endfunction

endpackage

// File: rtl/seq_karatsuba_mult_half.sv
// Combinational W x W -> 2W unsigned multiplier (karatsuba_half_mult).
// Power-of-two widths above 4 recurse one Karatsuba level into three
// W/2-bit instances of this same module; other widths (and the 4-bit leaf)
// use a plain shift-and-add array.
//   x, y : operands (W bits)
//   prod : x*y (2W bits)
module karatsuba_half_mult #(
    parameter int W = 8
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] prod
);

    localparam bit POW2 = ((W & (W - 1)) == 0);

    generate
        if (POW2 && (W > 4)) begin : g_kara
            localparam int HW = W / 2;

            logic [HW-1:0] xh, xl, yh, yl, dx, dy;
            logic [W-1:0]  hh, ll, mm;
            logic          neg;
            logic [2*W-1:0] mid;

            assign xh = x[W-1:HW];
            assign xl = x[HW-1:0];
            assign yh = y[W-1:HW];
            assign yl = y[HW-1:0];

            // (xl-xh)*(yh-yl) carried as magnitude plus sign
            assign dx  = (xl >= xh) ? (xl - xh) : (xh - xl);
            assign dy  = (yh >= yl) ? (yh - yl) : (yl - yh);
            assign neg = (xl < xh) ^ (yh < yl);

            karatsuba_half_mult #(.W(HW)) u_hh (.x(xh), .y(yh), .prod(hh));
            karatsuba_half_mult #(.W(HW)) u_ll (.x(xl), .y(yl), .prod(ll));
            karatsuba_half_mult #(.W(HW)) u_mm (.x(dx), .y(dy), .prod(mm));

            // Cross term is never negative, so modular 2W-bit arithmetic is exact
            assign mid = neg ? ({{W{1'b0}}, hh} + {{W{1'b0}}, ll} - {{W{1'b0}}, mm})
                             : ({{W{1'b0}}, hh} + {{W{1'b0}}, ll} + {{W{1'b0}}, mm});

            assign prod = {hh, ll} + (mid << HW);
        end else begin : g_array
            logic [2*W-1:0] acc;

            always_comb begin
                acc = '0;
                for (int i = 0; i < W; i++) begin
                    if (y[i]) begin
                        acc = acc + ({{W{1'b0}}, x} << i);
                    end
                end
            end

            assign prod = acc;
        end
    endgenerate

endmodule

// File: rtl/seq_karatsuba_mult.sv
// Sequential Karatsuba multiplier: one shared H-bit multiplier is reused for
// the high, low and middle partial products, then combined into a 2N-bit p.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b captured when both high)
//   a, b                : N-bit operands
//   sgn                 : two's-complement mode, only with SEQ_KARATSUBA_SIGNED_EN
//   out_valid/out_ready : product handshake (p stable while out_valid && !out_ready)
//   p                   : 2N-bit product
//   busy                : high whenever the FSM is not IDLE
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised by this block, stays high with stable
// data until the transfer.
// Optional feature macro: SEQ_KARATSUBA_SIGNED_EN (signed operand support).
module seq_karatsuba_mult
    import seq_karatsuba_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef SEQ_KARATSUBA_SIGNED_EN
    input  logic           sgn,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);

    localparam int H = half_width(N);

    generate
        if (!width_ok(N)) begin : g_bad_width
            $error("seq_karatsuba_mult: N must be even and >= 4");
        end
    endgenerate

    state_t state, state_next;

    logic [N-1:0]   a_q, b_q;
    logic [N-1:0]   t2, t0, m;
    logic           neg;
    logic [2*N-1:0] p_q;

    logic [H-1:0]   hm_x, hm_y;
    logic [N-1:0]   hm_prod;
    logic [H-1:0]   dx, dy;
    logic [N:0]     t1;
    logic [2*N-1:0] prod_full;
    logic [N-1:0]   a_in, b_in;

`ifdef SEQ_KARATSUBA_SIGNED_EN
    logic sign_q;
    // Magnitudes; -2^(N-1) maps to 2^(N-1) which fits as an unsigned N-bit value
    assign a_in = (sgn && a[N-1]) ? (~a + 1'b1) : a;
    assign b_in = (sgn && b[N-1]) ? (~b + 1'b1) : b;
`else
    assign a_in = a;
    assign b_in = b;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = MUL_HH;
            MUL_HH:  state_next = MUL_LL;
            MUL_LL:  state_next = MUL_MID;
            MUL_MID: state_next = COMBINE;
            COMBINE: state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign p         = p_q;

    // ---------------- shared half multiplier ----------------
    assign dx = (a_q[H-1:0] >= a_q[N-1:H]) ? (a_q[H-1:0] - a_q[N-1:H])
                                           : (a_q[N-1:H] - a_q[H-1:0]);
    assign dy = (b_q[N-1:H] >= b_q[H-1:0]) ? (b_q[N-1:H] - b_q[H-1:0])
                                           : (b_q[H-1:0] - b_q[N-1:H]);

    always_comb begin
        hm_x = '0;
        hm_y = '0;
        case (state)
            MUL_HH:  begin hm_x = a_q[N-1:H]; hm_y = b_q[N-1:H]; end
            MUL_LL:  begin hm_x = a_q[H-1:0]; hm_y = b_q[H-1:0]; end
            MUL_MID: begin hm_x = dx;         hm_y = dy;         end
            default: begin hm_x = '0;         hm_y = '0;         end
        endcase
    end

    karatsuba_half_mult #(.W(H)) u_half_mult (
        .x    (hm_x),
        .y    (hm_y),
        .prod (hm_prod)
    );

    // ---------------- combine ----------------
    // t1 = al*bh + ah*bl; the subtract branch never underflows for real operands
    assign t1 = neg ? ({1'b0, t0} + {1'b0, t2} - {1'b0, m})
                    : ({1'b0, t0} + {1'b0, t2} + {1'b0, m});

    // t2<<N + t0 is just the concatenation, since t0 is exactly N bits
    assign prod_full = {t2, t0} + ({{(N-1){1'b0}}, t1} << H);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            t2     <= '0;
            t0     <= '0;
            m      <= '0;
            neg    <= 1'b0;
            p_q    <= '0;
`ifdef SEQ_KARATSUBA_SIGNED_EN
            sign_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a_in;
                        b_q    <= b_in;
`ifdef SEQ_KARATSUBA_SIGNED_EN
                        sign_q <= sgn & (a[N-1] ^ b[N-1]);
`endif
                    end
                end
                MUL_HH:  t2 <= hm_prod;
                MUL_LL:  t0 <= hm_prod;
                MUL_MID: begin
                    m   <= hm_prod;
                    neg <= (a_q[H-1:0] < a_q[N-1:H]) ^ (b_q[N-1:H] < b_q[H-1:0]);
                end
                COMBINE: begin
`ifdef SEQ_KARATSUBA_SIGNED_EN
                    p_q <= sign_q ? (~prod_full + 1'b1) : prod_full;
`else
                    p_q <= prod_full;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
